seg7_capture: RTL



---
 rtl/seg7_capture_if.sv | 38 +++
 rtl/seg7_capture.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seg7_capture_if.sv
// Bundles the snooped display bus and the decoded read-back outputs of
// seg7_capture.
//
// Ports:
//   seg_n   : active-low segments, [7]=a .. [1]=g, [0]=dp
//   sel_n   : active-low digit selects, one low bit selects one digit
//   bcd     : decoded digit d at [4d+3:4d], 4'hF means blank
//   dp      : decimal point per digit, active-high
//   valid   : digit holds a fresh legal decode
//   err     : last committed pattern for the digit was illegal
//   upd     : one-cycle pulse on every commit
//   upd_idx : digit index of the current commit
//
// Modports:
//   master : the display side (drives seg_n/sel_n, observes the decode)
//   slave  : the capture block
interface seg7_capture_if #(
  parameter int NDIG = 4
);
  logic [7:0]        seg_n;
  logic [NDIG-1:0]   sel_n;
  logic [4*NDIG-1:0] bcd;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   valid;
  logic [NDIG-1:0]   err;
  logic              upd;
  logic [2:0]        upd_idx;

  modport master (
    output seg_n, sel_n,
    input  bcd, dp, valid, err, upd, upd_idx
  );

  modport slave (
    input  seg_n, sel_n,
    output bcd, dp, valid, err, upd, upd_idx
  );
endinterface

// File: rtl/seg7_capture.sv
// Reader side of a multiplexed 7-segment display. Samples the active-low
// segment bus and digit selects, waits for STABLE identical one-hot samples,
// then decodes the pattern into BCD/dp for the selected digit. Illegal
// patterns raise err, and digits not refreshed for TIMEOUT cycles lose valid.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seg7_capture_if.slave (seg_n/sel_n in, decoded outputs out)
module seg7_capture #(
  parameter int NDIG    = 4,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_capture_if.slave  bus
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int AW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    TRACK
  } state_t;

  state_t          state;
  logic [7:0]      seg_q;
  logic [NDIG-1:0] sel_q;
  logic [7:0]      cand_seg;
  logic [NDIG-1:0] cand_sel;
  logic [CW-1:0]   count;
  logic [AW-1:0]   age [NDIG];

  logic            onehot;
  logic            same;
  logic            commit;
  logic [2:0]      idx;
  logic            legal;
  logic [3:0]      code;

  // Maps the a..g pattern (0 = lit) to {legal, bcd}. Anything outside the
  // ten digits and the all-dark blank is illegal.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    case (p)
      7'b0000001: return {1'b1, 4'd0};
      7'b1001111: return {1'b1, 4'd1};
      7'b0010010: return {1'b1, 4'd2};
      7'b0000110: return {1'b1, 4'd3};
      7'b1001100: return {1'b1, 4'd4};
      7'b0100100: return {1'b1, 4'd5};
      7'b0100000: return {1'b1, 4'd6};
      7'b0001111: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0000100: return {1'b1, 4'd9};
      7'b1111111: return {1'b1, 4'hF};
      default:    return {1'b0, 4'h0};
    endcase
  endfunction

  // A sample only counts towards stability if exactly one select is low and
  // both select and segments (including dp) match the held candidate.
  assign onehot = $onehot(~sel_q);
  assign same   = (state == TRACK) && (sel_q == cand_sel) && (seg_q == cand_seg);
  assign commit = onehot && same && (count == CW'(STABLE - 1));
  assign {legal, code} = decode7(seg_q[7:1]);

  // Index of the single low select bit; only used when onehot is true.
  always_comb begin
    idx = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (!sel_q[d]) idx = 3'(d);
    end
  end

  // Input registers, stability FSM, per-digit commit and aging. The count
  // saturates at STABLE so a held pattern commits once; a commit on a digit
  // takes priority over its timeout in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      seg_q       <= '1;
      sel_q       <= '1;
      cand_seg    <= '0;
      cand_sel    <= '1;
      count       <= '0;
      bus.bcd     <= '0;
      bus.dp      <= '0;
      bus.valid   <= '0;
      bus.err     <= '0;
      bus.upd     <= 1'b0;
      bus.upd_idx <= '0;
      for (int d = 0; d < NDIG; d++) age[d] <= '0;
    end else begin
      seg_q   <= bus.seg_n;
      sel_q   <= bus.sel_n;
      bus.upd <= commit;
      if (commit) bus.upd_idx <= idx;

      if (!onehot) begin
        state <= IDLE;
        count <= '0;
      end else if (same) begin
        if (count != CW'(STABLE)) count <= count + 1'b1;
      end else begin
        state    <= TRACK;
        cand_sel <= sel_q;
        cand_seg <= seg_q;
        count    <= CW'(1);
      end

      for (int d = 0; d < NDIG; d++) begin
        if (commit && (idx == 3'(d)) && legal) begin
          bus.bcd[4*d +: 4] <= code;
          bus.dp[d]         <= ~seg_q[0];
          bus.valid[d]      <= 1'b1;
          bus.err[d]        <= 1'b0;
          age[d]            <= '0;
        end else begin
          if (age[d] != AW'(TIMEOUT)) age[d] <= age[d] + 1'b1;
          if (commit && (idx == 3'(d))) begin
            bus.err[d]   <= 1'b1;
            bus.valid[d] <= 1'b0;
          end else if (age[d] >= AW'(TIMEOUT - 1)) begin
            bus.valid[d] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
